ifetch_unit: RTL

- Instruction-fetch front end and requester side of the instruction-memory read port.
- Drives the word address into the combinational imem (data returned the same cycle).
- Buffers fetched words, each tagged with its PC, in a small FIFO and hands them to decode over a valid/ready handshake.
- Handles PC redirects (branch/jump/trap) by flushing the buffer and restarting fetch.

---
 rtl/ifetch_unit.sv | 114 +++++++++++
 1 files changed

// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction-fetch front end with a PC-tagged FIFO toward decode.
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   imem_addr/imem_data : combinational instruction-memory read port
//   redirect_valid/_pc  : one-cycle fetch restart request and its target
//   inst_valid/ready    : decode handshake for the FIFO head
//   inst_data/inst_pc   : head instruction word and its PC
//   IFETCH_PERF_EN      : when defined, adds perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pc_mem_q [DEPTH];
  logic [31:0]   pc_mem_d [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];
  logic [31:0]   data_mem_d [DEPTH];
  logic          pop, push;
  logic          unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign imem_addr  = fetch_pc_q;
  assign inst_valid = (count_q != '0);
  assign inst_data  = data_mem_q[rd_ptr_q];
  assign inst_pc    = pc_mem_q[rd_ptr_q];
  // A full FIFO still accepts a fetch when the head leaves in the same cycle.
  assign pop  = inst_valid & inst_ready;
  assign push = (count_q < FULL) | pop;
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    pc_mem_d   = pc_mem_q;
    data_mem_d = data_mem_q;
    if (redirect_valid) begin
      // Redirect discards this cycle's push/pop; the fetched word is from the old path.
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        pc_mem_d[wr_ptr_q]   = fetch_pc_q;
        data_mem_d[wr_ptr_q] = imem_data;
        wr_ptr_d             = wr_ptr_q + 1'b1;
        fetch_pc_d           = fetch_pc_q + 32'd4;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = (push & ~pop) ? count_q + 1'b1 : (pop & ~push) ? count_q - 1'b1 : count_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        data_mem_q[i] <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      pc_mem_q   <= pc_mem_d;
      data_mem_q <= data_mem_d;
    end
  end
`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d, stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  always_comb begin
    fetch_cnt_d = fetch_cnt_q + {31'd0, push & ~redirect_valid};
    stall_cnt_d = stall_cnt_q + {31'd0, (count_q == FULL) & ~pop & ~redirect_valid};
    flush_cnt_d = flush_cnt_q + {31'd0, redirect_valid};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif
endmodule
